// File: rtl/arm_controller.sv
// Control unit for a single-cycle ARM datapath.
// It decodes Instr[31:12], evaluates the condition field against the
// registered NZCV flags, and gates every state-changing strobe. It also
// keeps a sticky illegal-instruction status bit.
module arm_controller #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        PCSrc,
  output logic [3:0]  Flags,
  output logic        illegal
);

  // Instruction fields. Bit positions are relative to Instr[31:12].
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;

  assign cond  = Instr[19:16];
  assign op    = Instr[15:14];
  assign funct = Instr[13:8];
  assign rd    = Instr[3:0];
  assign cmd   = funct[4:1];

  // Raw decode results, before condition and legality gating.
  logic [1:0] reg_src_dec;
  logic [1:0] imm_src_dec;
  logic       alu_src_dec;
  logic [1:0] alu_ctrl_dec;
  logic       memtoreg_dec;
  logic       regw_dec;
  logic       memw_dec;
  logic       branch_dec;
  logic [1:0] flagw_dec;
  logic       illegal_dec;
  logic       pcs_dec;

  logic       illegal_now;
  logic       cond_ex;
  logic       strobe_en;

  logic [3:0] flags_reg;
  logic [3:0] flags_next;
  logic [1:0] flag_we;
  logic       illegal_reg;

  // Main opcode/function decode.
  always_comb begin
    reg_src_dec  = 2'b00;
    imm_src_dec  = 2'b00;
    alu_src_dec  = 1'b0;
    alu_ctrl_dec = 2'b00;
    memtoreg_dec = 1'b0;
    regw_dec     = 1'b0;
    memw_dec     = 1'b0;
    branch_dec   = 1'b0;
    flagw_dec    = 2'b00;
    illegal_dec  = 1'b0;
    case (op)
      2'b00: begin
        // Data processing: funct[5] selects an immediate operand.
        alu_src_dec = funct[5];
        regw_dec    = 1'b1;
        case (cmd)
          4'b0100: alu_ctrl_dec = 2'b00;  // ADD
          4'b0010: alu_ctrl_dec = 2'b01;  // SUB
          4'b0000: alu_ctrl_dec = 2'b10;  // AND
          4'b1100: alu_ctrl_dec = 2'b11;  // ORR
          default: illegal_dec  = 1'b1;
        endcase
        // Logical ops only touch NZ. Arithmetic ops also update CV.
        flagw_dec[1] = funct[0];
        flagw_dec[0] = funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010));
      end
      2'b01: begin
        // Memory: register-offset forms (funct[5]=1) are not supported.
        if (funct[5]) begin
          illegal_dec = 1'b1;
        end else begin
          alu_src_dec  = 1'b1;
          imm_src_dec  = 2'b01;
          alu_ctrl_dec = funct[3] ? 2'b00 : 2'b01;
          if (funct[0]) begin
            regw_dec     = 1'b1;
            memtoreg_dec = 1'b1;
          end else begin
            reg_src_dec = 2'b10;
            memw_dec    = 1'b1;
          end
        end
      end
      2'b10: begin
        // Branch: the link form has no return-address path, so it is rejected.
        if (funct[4]) begin
          illegal_dec = 1'b1;
        end else begin
          reg_src_dec = 2'b01;
          imm_src_dec = 2'b10;
          alu_src_dec = 1'b1;
          branch_dec  = 1'b1;
        end
      end
      default: illegal_dec = 1'b1;
    endcase
  end

  assign pcs_dec     = branch_dec | (regw_dec & (rd == 4'b1111));
  assign illegal_now = illegal_dec | (cond == 4'b1111);

  // Condition check uses the registered flags, i.e. the values before this
  // instruction updates them.
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_reg;
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // A strobe fires only for a legal instruction whose condition passes, and
  // never while reset is held.
  assign strobe_en = cond_ex & ~illegal_now & ~reset;

  assign RegWrite = regw_dec & strobe_en;
  assign MemWrite = memw_dec & strobe_en;
  assign PCSrc    = pcs_dec & strobe_en;

  // Non-strobe outputs follow decode but are forced low for illegal encodings.
  assign RegSrc     = illegal_now ? 2'b00 : reg_src_dec;
  assign ImmSrc     = illegal_now ? 2'b00 : imm_src_dec;
  assign ALUSrc     = illegal_now ? 1'b0  : alu_src_dec;
  assign ALUControl = illegal_now ? 2'b00 : alu_ctrl_dec;
  assign MemtoReg   = illegal_now ? 1'b0  : memtoreg_dec;

  // NZ and CV each have an independent write enable. An unselected half keeps
  // its old value.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag_half
      assign flag_we[gi] = flagw_dec[gi] & strobe_en;
      assign flags_next[2*gi+1:2*gi] = flag_we[gi] ? ALUFlags[2*gi+1:2*gi]
                                                   : flags_reg[2*gi+1:2*gi];
    end
  endgenerate

  // NZCV register. Reset wins over any pending update.
  always_ff @(posedge clk) begin
    if (reset) flags_reg <= FLAG_RESET;
    else       flags_reg <= flags_next;
  end

  // Sticky illegal status. It sets whatever the condition outcome and clears
  // only on reset.
  always_ff @(posedge clk) begin
    if (reset)            illegal_reg <= 1'b0;
    else if (illegal_now) illegal_reg <= 1'b1;
  end

  assign Flags   = flags_reg;
  assign illegal = illegal_reg;

endmodule

// File: doc/arm_controller.md
Name: arm_controller

Overview:
- Control unit for the single-cycle ARM datapath.
- Decodes Instr[31:12] into datapath control: RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc, plus MemWrite for data memory.
- Holds the architectural NZCV flag register, evaluates the condition field, and gates all state-changing strobes.
- Flags a sticky illegal-instruction status.

Parameters:
- FLAG_RESET, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- Instr  in  20  Instr[31:12]: cond[31:28], op[27:26], funct[25:20], Rd[15:12].
- ALUFlags  in  4  {N,Z,C,V} from datapath ALU, current cycle.
- RegSrc  out  2  RA1/RA2 select.
- RegWrite  out  1  register file write enable.
- ImmSrc  out  2  extender mode.
- ALUSrc  out  1  0 = register, 1 = ExtImm.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- MemtoReg  out  1  result select.
- MemWrite  out  1  data memory write enable.
- PCSrc  out  1  PC takes Result.
- Flags  out  4  registered NZCV.
- illegal  out  1  sticky illegal-instruction flag.

Behaviour:
Decode (combinational):
- op=00 (data processing):
  - I = funct[5], cmd = funct[4:1], S = funct[0].
  - RegSrc=00, ImmSrc=00, ALUSrc=I, RegW=1, MemW=0, MemtoReg=0.
  - cmd 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR. Any other cmd is illegal.
  - FlagW[1] = S (NZ). FlagW[0] = S & (ADD|SUB) (CV).
- op=01 (memory):
  - funct[5] must be 0, otherwise illegal.
  - ALUSrc=1, ImmSrc=01, ALUControl = funct[3] ? 00 : 01 (U bit), FlagW=00.
  - L = funct[0]=1 (LDR): RegSrc=00, RegW=1, MemtoReg=1, MemW=0.
  - L=0 (STR): RegSrc=10, RegW=0, MemW=1.
- op=10 (branch):
  - funct[4]=1 (BL) is illegal.
  - Otherwise RegSrc=x1, ImmSrc=10, ALUSrc=1, ALUControl=00, Branch=1, RegW=0, MemW=0, FlagW=00.
- op=11: illegal.
- PCS = Branch | (RegW & Rd==4'b1111).

Condition (from registered Flags, i.e. pre-update values):
- EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
- HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V).
- AL 1.
- cond=1111: CondEx=0 and the instruction is illegal.

Gating:
- RegWrite = RegW & CondEx & ~illegal_now & ~reset. MemWrite and PCSrc are gated identically.
- Non-strobe outputs follow decode regardless of CondEx.
- For illegal encodings, non-strobe outputs drive 0.

Flag register:
- On rising edge: if reset, Flags <= FLAG_RESET.
- Else Flags[3:2] <= ALUFlags[3:2] when FlagW[1]&CondEx&~illegal_now.
- Else Flags[1:0] <= ALUFlags[1:0] when FlagW[0]&CondEx&~illegal_now.
- Unselected halves hold.
- New flags are visible to the next instruction only (1-cycle latency). The same-cycle condition check uses old flags.

Illegal:
- illegal_now is a combinational decode result.
- The illegal register sets on the edge after illegal_now=1, independent of CondEx.
- It stays set until reset. Reset clears it to 0; reset has priority over set in the same edge.

Reset:
- While reset=1, all strobes are 0. Flags and illegal load their reset values at the edge.
- Reset asserted mid-stream discards any pending flag update in that cycle.

Test Plan:
- ADDS R1,R2,#5 (Instr[31:12]=0xE2921), ALUFlags=0100 → RegWrite=1, ALUSrc=1, ALUControl=00, ImmSrc=00; Flags=0100 after next edge.
- With Flags=1111, ANDS (0xE0121), ALUFlags=0000 → Flags=0011 next cycle (CV preserved). Then SUBS (0xE0521), ALUFlags=1010 → Flags=1010.
- BEQ (0x0A000): Flags Z=1 → PCSrc=1, ImmSrc=10, RegSrc[0]=1. Flags Z=0 → PCSrc=0. cond=1110 → PCSrc=1 regardless.
- STR (0xE5821) → MemWrite=1, RegSrc=10, ImmSrc=01, ALUControl=00, RegWrite=0. LDR U=0 (0xE5121) → ALUControl=01, MemtoReg=1, RegWrite=1.
- ADD R15 (0xE082F) → PCSrc=1, RegWrite=1. Same with cond NE while Z=1 → PCSrc=0, RegWrite=0, Flags unchanged.
- op=11 (0xEC000) → all strobes 0, no flag change, illegal=1 next edge and held through valid instructions. Assert reset with a simultaneous illegal instruction → illegal=0, Flags=FLAG_RESET.
